if_prefetch_stage: RTL and testbench

Parametrised instruction-fetch stage for the five-stage LoongArch pipeline, replacing the single-entry IF stage. Drives an SRAM-like instruction bus (req/addr_ok/data_ok) with up to MAX_OUTSTANDING requests in flight. Buffers returned instructions in a FIFO of FIFO_DEPTH entries, presented to ID as {pc, inst}. Branch redirects from EX flush the FIFO and silently discard stale in-flight responses.

---
 rtl/if_prefetch_stage_pkg.sv | 10 +
 rtl/if_prefetch_stage_inst_fifo.sv | 71 +++++++
 rtl/if_prefetch_stage.sv | 157 +++++++++++++++
 tb/tb_if_prefetch_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_prefetch_stage_pkg.sv
// Shared constants for the instruction-fetch prefetch stage: ID payload width,
// default reset PC, NOP encoding and the SRAM word-size code.
package if_prefetch_stage_pkg;

    localparam int          TO_ID_W          = 64;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;
    localparam logic [31:0] INST_NOP         = 32'h0340_0000;
    localparam logic [1:0]  SRAM_SIZE_WORD   = 2'b10;

endpackage

// File: rtl/if_prefetch_stage_inst_fifo.sv
// Synchronous FIFO with flush and a registered head entry; the head updates
// one cycle after a push, so there is no combinational push-to-head bypass.
module if_inst_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       head_valid_o,
    output logic [WIDTH-1:0]           head_data_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, wr_ptr_q, rd_next_s;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             valid_q;
    logic             do_push_s, do_pop_s;

    // Next head: a push into a slot that becomes the head is taken directly.
    always_comb begin
        do_pop_s  = pop_i & (count_q != '0);
        do_push_s = push_i & ((count_q != CW'(DEPTH)) | do_pop_s);
        rd_next_s = do_pop_s ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        count_d   = count_q + CW'(do_push_s) - CW'(do_pop_s);
        if (do_push_s && (wr_ptr_q == rd_next_s)) begin
            head_d = push_data_i;
        end else begin
            head_d = mem_q[rd_next_s];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            rd_ptr_q <= rd_next_s;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= (count_d != '0);
        end
    end

    assign count_o      = count_q;
    assign head_valid_o = valid_q;
    assign head_data_o  = head_q;

endmodule

// File: rtl/if_prefetch_stage.sv
// Prefetching IF stage: credit-limited SRAM-like fetch with an instruction FIFO.
// Optional macro IF_ADEF_CHECK_EN enables the fetch-address alignment exception.
module if_prefetch_stage
    import if_prefetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic               clk,
    input  logic               resetn,
    output logic               inst_sram_req,
    output logic               inst_sram_wr,
    output logic [1:0]         inst_sram_size,
    output logic [3:0]         inst_sram_wstrb,
    output logic [31:0]        inst_sram_addr,
    output logic [31:0]        inst_sram_wdata,
    input  logic               inst_sram_addr_ok,
    input  logic               inst_sram_data_ok,
    input  logic [31:0]        inst_sram_rdata,
    input  logic               br_taken,
    input  logic [31:0]        br_target,
    input  logic               id_allow_in,
    output logic               if_to_id_valid,
    output logic [TO_ID_W-1:0] to_id_data,
    output logic               if_adef
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
`ifdef IF_ADEF_CHECK_EN
    localparam int FW = TO_ID_W + 1;
`else
    localparam int FW = TO_ID_W;
`endif

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [OW-1:0] out_q, out_d, disc_q, disc_d;
    logic [31:0]   pcq_mem_q [MAX_OUTSTANDING];
    logic [PW-1:0] pcq_rd_q, pcq_wr_q;
    logic          credit_s, base_req_s, accept_s, dok_s, data_push_s, push_s, pop_s;
    logic [FW-1:0] push_data_s, head_s;
    logic [CW-1:0] fifo_cnt_s;

    function automatic logic [PW-1:0] pcq_inc(input logic [PW-1:0] p);
        if (p == PW'(MAX_OUTSTANDING - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    // In-flight requests also reserve FIFO space, so a push can never overflow.
    assign credit_s    = (out_q < OW'(MAX_OUTSTANDING)) &&
                         ((32'(out_q) + 32'(fifo_cnt_s)) < 32'(FIFO_DEPTH));
    assign base_req_s  = resetn & ~br_taken & credit_s;
    assign accept_s    = inst_sram_req & inst_sram_addr_ok;
    assign dok_s       = inst_sram_data_ok & (out_q != '0);
    assign data_push_s = dok_s & (disc_q == '0) & ~br_taken;
    assign pop_s       = if_to_id_valid & id_allow_in & ~br_taken;

`ifdef IF_ADEF_CHECK_EN
    logic misalign_s, adef_push_s, adef_done_q;
    assign misalign_s    = (fetch_pc_q[1:0] != 2'b00);
    assign adef_push_s   = misalign_s & ~adef_done_q & ~br_taken & (out_q == '0) &
                           (32'(fifo_cnt_s) < 32'(FIFO_DEPTH));
    assign inst_sram_req = base_req_s & ~misalign_s;
    assign push_s        = data_push_s | adef_push_s;
    assign push_data_s   = adef_push_s ? {1'b1, fetch_pc_q, 32'h0000_0000}
                                       : {1'b0, pcq_mem_q[pcq_rd_q], inst_sram_rdata};
    assign if_adef       = head_s[TO_ID_W];

    // One exception entry per misaligned target; rearmed by the next redirect.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            adef_done_q <= 1'b0;
        end else if (br_taken) begin
            adef_done_q <= 1'b0;
        end else if (adef_push_s) begin
            adef_done_q <= 1'b1;
        end else begin
            adef_done_q <= adef_done_q;
        end
    end
`else
    assign inst_sram_req = base_req_s;
    assign push_s        = data_push_s;
    assign push_data_s   = {pcq_mem_q[pcq_rd_q], inst_sram_rdata};
    assign if_adef       = 1'b0;
`endif

    // After a redirect every response still in flight is stale and gets dropped.
    always_comb begin
        if (br_taken) begin
            fetch_pc_d = br_target;
        end else if (accept_s) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end else begin
            fetch_pc_d = fetch_pc_q;
        end
        out_d = out_q + OW'(accept_s) - OW'(dok_s);
        if (br_taken) begin
            disc_d = out_d;
        end else if (dok_s && (disc_q != '0)) begin
            disc_d = disc_q - OW'(1);
        end else begin
            disc_d = disc_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc_q <= RESET_PC;
            out_q      <= '0;
            disc_q     <= '0;
            pcq_rd_q   <= '0;
            pcq_wr_q   <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                pcq_mem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            out_q      <= out_d;
            disc_q     <= disc_d;
            if (accept_s) begin
                pcq_mem_q[pcq_wr_q] <= fetch_pc_q;
                pcq_wr_q            <= pcq_inc(pcq_wr_q);
            end
            if (dok_s) begin
                pcq_rd_q <= pcq_inc(pcq_rd_q);
            end
        end
    end

    if_inst_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_inst_fifo (
        .clk          (clk),
        .resetn       (resetn),
        .push_i       (push_s),
        .push_data_i  (push_data_s),
        .pop_i        (pop_s),
        .flush_i      (br_taken),
        .count_o      (fifo_cnt_s),
        .head_valid_o (if_to_id_valid),
        .head_data_o  (head_s)
    );

    assign to_id_data      = head_s[TO_ID_W-1:0];
    assign inst_sram_addr  = fetch_pc_q;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = SRAM_SIZE_WORD;
    assign inst_sram_wstrb = 4'h0;
    assign inst_sram_wdata = 32'h0000_0000;

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Scoreboard bench for if_prefetch_stage: a bus model answers in order, the
// expected {pc, inst} stream is queued at response time and compared on ID pop.
module tb_if_prefetch_stage;

    logic        clk;
    logic        resetn;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        br_taken;
    logic [31:0] br_target;
    logic        id_allow_in;
    logic        if_to_id_valid;
    logic [63:0] to_id_data;
    logic        if_adef;

    if_prefetch_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .br_taken          (br_taken),
        .br_target         (br_target),
        .id_allow_in       (id_allow_in),
        .if_to_id_valid    (if_to_id_valid),
        .to_id_data        (to_id_data),
        .if_adef           (if_adef)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] pend_addr[$];
    bit          pend_stale[$];
    int          pend_due[$];

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          lat = 1;
    bit          addr_ok_en = 1'b1;
    bit          allow = 1'b1;
    bit          br_req = 1'b0;
    bit          br_prev = 1'b0;
    logic [31:0] br_tgt_v = 32'h0;
    logic [31:0] exp_pc = 32'h1c00_0000;
    bit          first_pc_chk = 1'b0;
    logic [31:0] first_pc_exp = 32'h0;
    logic        s_req, s_valid, s_adef;
    logic [31:0] s_addr;
    logic [63:0] s_data;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5a5a_a5a5;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One bus/ID cycle: drive at negedge, sample 1ns later, update the model.
    task automatic cycle();
        exp_t        e;
        logic [31:0] a;
        bit          st;
        int          d;
        @(negedge clk);
        inst_sram_addr_ok = addr_ok_en;
        if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
            inst_sram_data_ok = 1'b1;
            inst_sram_rdata   = inst_of(pend_addr[0]);
        end else begin
            inst_sram_data_ok = 1'b0;
            inst_sram_rdata   = 32'h0;
        end
        br_taken    = br_req;
        br_target   = br_tgt_v;
        id_allow_in = allow;
        #1;
        s_req = inst_sram_req; s_addr = inst_sram_addr;
        s_valid = if_to_id_valid; s_data = to_id_data; s_adef = if_adef;
        if (br_req) begin
            chk("req_in_br_cycle", s_req, 0);
            foreach (pend_stale[i]) pend_stale[i] = 1'b1;
            exp_q.delete();
            exp_pc = br_tgt_v;
`ifdef IF_ADEF_CHECK_EN
            if (br_tgt_v[1:0] != 2'b00) exp_q.push_back({br_tgt_v, 32'h0, 1'b1});
`endif
        end else begin
            if (br_prev) chk("valid_after_br", s_valid, 0);
`ifdef IF_ADEF_CHECK_EN
            if (exp_pc[1:0] != 2'b00) chk("adef_no_req", s_req, 0);
`endif
            if (allow) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", s_valid, 0);
                end else if (s_valid) begin
                    e = exp_q.pop_front();
                    chk("to_id_data", s_data, {e.pc, e.inst});
                    chk("if_adef", s_adef, e.adef);
                    if (first_pc_chk) begin
                        chk("first_pc_after_br", s_data[63:32], first_pc_exp);
                        first_pc_chk = 1'b0;
                    end
                end
            end
        end
        if (inst_sram_data_ok) begin
            a  = pend_addr.pop_front();
            st = pend_stale.pop_front();
            d  = pend_due.pop_front();
            if (!st && !br_req) exp_q.push_back({a, inst_of(a), 1'b0});
        end
        if (s_req && addr_ok_en) begin
            chk("fetch_addr", s_addr, exp_pc);
            pend_addr.push_back(s_addr);
            pend_stale.push_back(1'b0);
            pend_due.push_back(cyc + lat);
            exp_pc = exp_pc + 32'd4;
        end
        br_prev = br_req;
        br_req  = 1'b0;
        cyc++;
    endtask

    task automatic redirect(input logic [31:0] tgt);
        br_req = 1'b1;
        br_tgt_v = tgt;
        first_pc_chk = (tgt[1:0] == 2'b00);
        first_pc_exp = tgt;
        cycle();
    endtask

    logic [31:0] a0;

    initial begin
        resetn = 1'b0;
        inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = 32'h0;
        br_taken = 1'b0; br_target = 32'h0; id_allow_in = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req", inst_sram_req, 0);
        chk("rst_valid", if_to_id_valid, 0);
        chk("rst_data", to_id_data, 64'h0);
        chk("rst_adef", if_adef, 0);
        chk("rst_size", inst_sram_size, 2'b10);

        // Reset release with a one-cycle bus.
        @(posedge clk); #2 resetn = 1'b1;
        cycle();
        chk("first_req", s_req, 1);
        chk("first_addr", s_addr, 32'h1c00_0000);
        chk("valid_c0", s_valid, 0);
        cycle();
        cycle();
        chk("first_valid", s_valid, 1);
        chk("first_data", s_data, {32'h1c00_0000, inst_of(32'h1c00_0000)});
        repeat (8) cycle();

        // ID stall: FIFO fills to its depth, fetch stops, nothing is lost.
        allow = 1'b0;
        repeat (20) cycle();
        chk("stall_req_low", s_req, 0);
        chk("stall_depth", exp_q.size(), 4);
        chk("stall_valid", s_valid, 1);
        allow = 1'b1;
        repeat (10) cycle();

        // Redirect with two responses outstanding.
        lat = 3;
        for (int i = 0; i < 40 && pend_addr.size() != 2; i++) cycle();
        chk("two_outstanding", pend_addr.size(), 2);
        redirect(32'h1c00_0100);
        repeat (15) cycle();
        chk("br1_first_seen", first_pc_chk, 0);

        // Redirect in the same cycle as data_ok with addr_ok high.
        lat = 1;
        for (int i = 0; i < 20 && !(pend_addr.size() != 0 && pend_due[0] <= cyc); i++) cycle();
        chk("dok_pending", (pend_addr.size() != 0 && pend_due[0] <= cyc), 1);
        redirect(32'h1c00_0200);
        repeat (10) cycle();
        chk("br2_first_seen", first_pc_chk, 0);

        // addr_ok withheld: request and address must hold.
        addr_ok_en = 1'b0;
        repeat (2) cycle();
        a0 = s_addr;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("hold_req", s_req, 1);
            chk("hold_addr", s_addr, a0);
        end
        addr_ok_en = 1'b1;
        repeat (8) cycle();

`ifdef IF_ADEF_CHECK_EN
        // Misaligned target: one exception entry, no bus traffic until redirect.
        redirect(32'h1c00_0102);
        repeat (10) cycle();
        chk("adef_consumed", exp_q.size(), 0);
        redirect(32'h1c00_0300);
        repeat (8) cycle();
`endif

        // Drain: no new requests, everything queued must reach ID.
        addr_ok_en = 1'b0;
        repeat (12) cycle();
        chk("drain_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
